mp_icache_ctrl_responder: RTL and testbench
===========================================

// Module: mp_icache_ctrl_responder
// PURPOSE
//  Cache-side (slave) end of the multi-port icache control bus. Accepts bypass, full-flush and
//  selective-flush requests from the cluster icache control unit, sequences them onto the tag
//  array invalidation port and core fetch stalls, and returns the acks. Also maintains the
//  global and per-bank hit/transaction/miss counters read back by the control unit.
// PARAMETERS
//  NB_CORES  4    fetch ports == cache banks; bypass_ack is NB_CORES+1 wide (+1 = refill engine)
//  NB_SETS   64   sets swept by a full flush (power of 2, >=2); SET_W = $clog2(NB_SETS)
// PORTS
//  clk_i                 in   1              clock
//  rst_ni                in   1              async reset, active low
//  bypass_req_i          in   1              level: 1 = bypass cache
//  bypass_ack_o          out  NB_CORES+1     per-port applied bypass mode; [NB_CORES] = refill engine
//  flush_req_i           in   1              full flush request (4-phase)
//  flush_ack_o           out  1              full flush ack (4-phase)
//  sel_flush_req_i       in   1              selective flush request (4-phase)
//  sel_flush_addr_i      in   32             address to invalidate
//  sel_flush_ack_o       out  1              selective flush ack (4-phase)
//  ctrl_clear_regs_i     in   1              clear all counters
//  ctrl_enable_regs_i    in   1              counting enable
//  global_hit_count_o    out  32             sum of bank hits
//  global_trans_count_o  out  32             sum of bank transactions
//  global_miss_count_o   out  32             sum of bank misses
//  bank_hit_count_o      out  NB_CORES x 32  per-bank hits
//  bank_trans_count_o    out  NB_CORES x 32  per-bank transactions
//  bank_miss_count_o     out  NB_CORES x 32  per-bank misses
//  core_idle_i           in   NB_CORES+1     port has no outstanding fetch/refill
//  bank_hit_i / bank_trans_i / bank_miss_i   in NB_CORES  one-cycle event pulses per bank
//  bypass_en_o           out  NB_CORES+1     bypass mode driven to each port
//  fetch_stall_o         out  1              stall all fetch ports
//  inval_req_o           out  1              invalidation request to tag arrays
//  inval_sel_o           out  1              0 = whole set inval_set_o, 1 = address inval_addr_o
//  inval_set_o           out  SET_W          set index
//  inval_addr_o          out  32             address for selective invalidation
//  inval_gnt_i           in   1              invalidation accepted this cycle
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, FSM IDLE.
//  Bypass: per port i independently, when bypass_en_o[i] != bypass_req_i and core_idle_i[i]=1,
//   next cycle bypass_en_o[i] <= bypass_req_i and bypass_ack_o[i] <= bypass_req_i (ack == en).
//   Non-idle port keeps old mode; bypass_req_i may toggle back before apply (no change, no ack).
//  Flush FSM: IDLE, SWEEP, SEL, DONE_F, DONE_S.
//   IDLE: flush_req_i -> SWEEP (set_cnt=0); else sel_flush_req_i -> SEL (capture addr).
//    Both high same cycle: full flush wins; sel stays pending, served after DONE_F.
//   SWEEP: fetch_stall_o=1, inval_req_o=1, inval_sel_o=0, inval_set_o=set_cnt; on gnt set_cnt++;
//    gnt with set_cnt==NB_SETS-1 -> DONE_F. Outputs stable while req && !gnt.
//   SEL: fetch_stall_o=1, inval_req_o=1, inval_sel_o=1, inval_addr_o=captured addr; gnt -> DONE_S.
//   DONE_F/DONE_S: flush_ack_o/sel_flush_ack_o=1, held until matching req low, then IDLE (ack 0).
//  Min latency: full flush req->ack = NB_SETS+1 cycles with gnt tied 1; selective = 2 cycles.
//  Counters: registered, 32-bit, saturate at 32'hFFFF_FFFF (no wrap).
//   clear has priority over enable; clear zeroes all 6 groups next cycle, same-cycle events dropped.
//   enable=0: hold. bank_x[i] += bank_x_i[i]; global_x += popcount(bank_x_i) (0..NB_CORES/cycle),
//   saturating; a global value may thus differ from the bank sum only after saturation.
//  Async reset mid-flush aborts: FSM IDLE, inval_req_o/fetch_stall_o/acks drop immediately.
// TESTING
//  1 reset -> all acks, bypass_en_o, counters, inval_req_o = 0; FSM IDLE.
//  2 bypass_req=1, core_idle=5'b10111 -> ack=5'b10111 next cycle; core3 idle -> ack=5'b11111.
//  3 NB_SETS=64, gnt=1, flush_req -> inval_set 0..63 on consecutive cycles, ack @65, clears when req drops.
//  4 flush_req & sel_flush_req same cycle, addr=0x1C00_8040 -> full sweep+ack first, then sel inval addr, sel ack.
//  5 enable=1, bank_hit=4'b1011 for 3 cycles -> bank_hit={3,0,3,3}, global_hit=9; clear+events -> all 0.
//  6 bank_miss[0] preset 0xFFFF_FFFE, two pulses -> 0xFFFF_FFFF, no wrap; rst_ni low during SWEEP -> req/stall 0 at once.

Source files
------------

// File: rtl/mp_icache_ctrl_if.sv
// -----------------------------------------------------------------------------
// mp_icache_ctrl_if
// Control bus between the cluster icache control unit (master) and the cache
// side responder (slave).
//   bypass_req / bypass_ack        : bypass mode request (level) and per-port
//                                    applied mode ([NB_CORES] = refill engine)
//   flush_req / flush_ack          : full flush, 4-phase handshake
//   sel_flush_req / _addr / _ack   : selective (single address) flush, 4-phase
//   ctrl_clear_regs / _enable_regs : performance counter clear / enable
//   global_*_count / bank_*_count  : hit / transaction / miss counters
// -----------------------------------------------------------------------------
interface mp_icache_ctrl_if #(
  parameter int NB_CORES = 4
);
  logic                          bypass_req;
  logic [NB_CORES:0]             bypass_ack;
  logic                          flush_req;
  logic                          flush_ack;
  logic                          sel_flush_req;
  logic [31:0]                   sel_flush_addr;
  logic                          sel_flush_ack;
  logic                          ctrl_clear_regs;
  logic                          ctrl_enable_regs;
  logic [31:0]                   global_hit_count;
  logic [31:0]                   global_trans_count;
  logic [31:0]                   global_miss_count;
  logic [NB_CORES-1:0][31:0]     bank_hit_count;
  logic [NB_CORES-1:0][31:0]     bank_trans_count;
  logic [NB_CORES-1:0][31:0]     bank_miss_count;

  modport master (
    output bypass_req, flush_req, sel_flush_req, sel_flush_addr,
           ctrl_clear_regs, ctrl_enable_regs,
    input  bypass_ack, flush_ack, sel_flush_ack,
           global_hit_count, global_trans_count, global_miss_count,
           bank_hit_count, bank_trans_count, bank_miss_count
  );

  modport slave (
    input  bypass_req, flush_req, sel_flush_req, sel_flush_addr,
           ctrl_clear_regs, ctrl_enable_regs,
    output bypass_ack, flush_ack, sel_flush_ack,
           global_hit_count, global_trans_count, global_miss_count,
           bank_hit_count, bank_trans_count, bank_miss_count
  );
endinterface

// File: rtl/mp_icache_ctrl_responder.sv
// -----------------------------------------------------------------------------
// mp_icache_ctrl_responder
// Cache-side end of the multi-port icache control bus. Applies bypass mode per
// fetch port once that port is idle, sequences full and selective flushes onto
// the tag-array invalidation port while stalling fetch, returns the 4-phase
// acks, and keeps saturating per-bank and global performance counters.
// Ports:
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   ctrl                : control bus (slave side)
//   core_idle_i         : per port (incl. refill engine) no outstanding access
//   bank_*_i            : one-cycle hit / transaction / miss pulses per bank
//   bypass_en_o         : bypass mode driven to each port
//   fetch_stall_o       : stall all fetch ports while invalidating
//   inval_req_o/_sel_o  : invalidation request; sel 0 = set, 1 = address
//   inval_set_o/_addr_o : set index / address to invalidate
//   inval_gnt_i         : invalidation accepted this cycle
// -----------------------------------------------------------------------------
module mp_icache_ctrl_responder #(
  parameter  int NB_CORES = 4,
  parameter  int NB_SETS  = 64,
  localparam int SET_W    = $clog2(NB_SETS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  mp_icache_ctrl_if.slave      ctrl,
  input  logic [NB_CORES:0]    core_idle_i,
  input  logic [NB_CORES-1:0]  bank_hit_i,
  input  logic [NB_CORES-1:0]  bank_trans_i,
  input  logic [NB_CORES-1:0]  bank_miss_i,
  output logic [NB_CORES:0]    bypass_en_o,
  output logic                 fetch_stall_o,
  output logic                 inval_req_o,
  output logic                 inval_sel_o,
  output logic [SET_W-1:0]     inval_set_o,
  output logic [31:0]          inval_addr_o,
  input  logic                 inval_gnt_i
);

  typedef enum logic [2:0] {S_IDLE, S_SWEEP, S_SEL, S_DONE_F, S_DONE_S} state_e;

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NB_SETS - 1);
  localparam int               N_GRP    = 3;  // 0 = hit, 1 = trans, 2 = miss

  state_e                               r_state;
  logic [SET_W-1:0]                     r_set_cnt;
  logic [31:0]                          r_inval_addr;
  logic                                 r_inval_req;
  logic                                 r_inval_sel;
  logic                                 r_fetch_stall;
  logic                                 r_flush_ack;
  logic                                 r_sel_ack;
  logic [NB_CORES:0]                    r_bypass_en;
  logic [N_GRP-1:0][NB_CORES-1:0][31:0] r_bank;
  logic [N_GRP-1:0][31:0]               r_glob;
  logic [N_GRP-1:0][NB_CORES-1:0]       w_ev;

  assign w_ev = {bank_miss_i, bank_trans_i, bank_hit_i};

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, inc};
    return s[32] ? '1 : s[31:0];
  endfunction

  // Flush sequencer. Outputs are registered next to the state so the
  // invalidation port sees glitch-free, stable values while waiting for grant.
  // NOTE: the reset branch is asynchronous, so an abort mid-flush drops the
  // request, stall and acks immediately rather than at the next edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin : flush_fsm
    if (!rst_ni) begin
      r_state       <= S_IDLE;
      r_set_cnt     <= '0;
      r_inval_addr  <= '0;
      r_inval_req   <= 1'b0;
      r_inval_sel   <= 1'b0;
      r_fetch_stall <= 1'b0;
      r_flush_ack   <= 1'b0;
      r_sel_ack     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the values
      // from before this edge, independent of statement order.
      case (r_state)
        S_IDLE: begin
          // Full flush wins a tie; a pending selective request is still high
          // when the full flush handshake completes and is served then.
          if (ctrl.flush_req) begin
            r_state       <= S_SWEEP;
            r_set_cnt     <= '0;
            r_inval_sel   <= 1'b0;
            r_inval_req   <= 1'b1;
            r_fetch_stall <= 1'b1;
          end else if (ctrl.sel_flush_req) begin
            r_state       <= S_SEL;
            r_inval_addr  <= ctrl.sel_flush_addr;
            r_inval_sel   <= 1'b1;
            r_inval_req   <= 1'b1;
            r_fetch_stall <= 1'b1;
          end
        end
        S_SWEEP: begin
          if (inval_gnt_i) begin
            if (r_set_cnt == LAST_SET) begin
              r_state       <= S_DONE_F;
              r_set_cnt     <= '0;
              r_inval_req   <= 1'b0;
              r_fetch_stall <= 1'b0;
              r_flush_ack   <= 1'b1;
            end else begin
              r_set_cnt <= r_set_cnt + SET_W'(1);
            end
          end
        end
        S_SEL: begin
          if (inval_gnt_i) begin
            r_state       <= S_DONE_S;
            r_inval_req   <= 1'b0;
            r_inval_sel   <= 1'b0;
            r_fetch_stall <= 1'b0;
            r_sel_ack     <= 1'b1;
          end
        end
        S_DONE_F: begin
          if (!ctrl.flush_req) begin
            r_state     <= S_IDLE;
            r_flush_ack <= 1'b0;
          end
        end
        S_DONE_S: begin
          if (!ctrl.sel_flush_req) begin
            r_state   <= S_IDLE;
            r_sel_ack <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_inval_req   <= 1'b0;
          r_fetch_stall <= 1'b0;
          r_flush_ack   <= 1'b0;
          r_sel_ack     <= 1'b0;
        end
      endcase
    end
  end

  // An idle port adopts the requested mode; a busy port keeps its old mode,
  // so a request that toggles back before the port idles leaves no trace.
  always_ff @(posedge clk_i or negedge rst_ni) begin : bypass_apply
    if (!rst_ni) begin
      r_bypass_en <= '0;
    end else begin
      r_bypass_en <= (core_idle_i & {(NB_CORES+1){ctrl.bypass_req}}) |
                     (~core_idle_i & r_bypass_en);
    end
  end

  // Global counters add the event popcount of all banks; both saturate
  // independently, so they only disagree with the bank sum after saturation.
  always_ff @(posedge clk_i or negedge rst_ni) begin : perf_counters
    if (!rst_ni) begin
      r_bank <= '0;
      r_glob <= '0;
    end else if (ctrl.ctrl_clear_regs) begin
      r_bank <= '0;
      r_glob <= '0;
    end else if (ctrl.ctrl_enable_regs) begin
      for (int g = 0; g < N_GRP; g++) begin
        for (int i = 0; i < NB_CORES; i++) begin
          r_bank[g][i] <= sat_add(r_bank[g][i], 32'(w_ev[g][i]));
        end
        r_glob[g] <= sat_add(r_glob[g], 32'($countones(w_ev[g])));
      end
    end
  end

  assign ctrl.bypass_ack         = r_bypass_en;
  assign ctrl.flush_ack          = r_flush_ack;
  assign ctrl.sel_flush_ack      = r_sel_ack;
  assign ctrl.bank_hit_count     = r_bank[0];
  assign ctrl.bank_trans_count   = r_bank[1];
  assign ctrl.bank_miss_count    = r_bank[2];
  assign ctrl.global_hit_count   = r_glob[0];
  assign ctrl.global_trans_count = r_glob[1];
  assign ctrl.global_miss_count  = r_glob[2];

  assign bypass_en_o   = r_bypass_en;
  assign fetch_stall_o = r_fetch_stall;
  assign inval_req_o   = r_inval_req;
  assign inval_sel_o   = r_inval_sel;
  assign inval_set_o   = r_set_cnt;
  assign inval_addr_o  = r_inval_addr;

endmodule

// File: tb/tb_mp_icache_ctrl_responder.sv
// -----------------------------------------------------------------------------
// tb_mp_icache_ctrl_responder
// Self-checking bench: flush stimulus pushes the expected invalidations and
// acks into queues, a forked monitor pops and compares them whenever the DUT
// grants an invalidation or raises an ack. Bypass and counters are compared
// against a behavioural model updated once per clock.
// -----------------------------------------------------------------------------
module tb_mp_icache_ctrl_responder;
  localparam int NB_CORES = 4;
  localparam int NB_SETS  = 64;
  localparam int SET_W    = 6;
  localparam longint unsigned SAT = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mp_icache_ctrl_if #(.NB_CORES(NB_CORES)) bus_if ();

  logic [NB_CORES:0]   core_idle;
  logic [NB_CORES:0]   bypass_en;
  logic [NB_CORES-1:0] bank_hit, bank_trans, bank_miss;
  logic                fetch_stall, inval_req, inval_sel, inval_gnt;
  logic [SET_W-1:0]    inval_set;
  logic [31:0]         inval_addr;

  mp_icache_ctrl_responder #(.NB_CORES(NB_CORES), .NB_SETS(NB_SETS)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .ctrl          (bus_if),
    .core_idle_i   (core_idle),
    .bank_hit_i    (bank_hit),
    .bank_trans_i  (bank_trans),
    .bank_miss_i   (bank_miss),
    .bypass_en_o   (bypass_en),
    .fetch_stall_o (fetch_stall),
    .inval_req_o   (inval_req),
    .inval_sel_o   (inval_sel),
    .inval_set_o   (inval_set),
    .inval_addr_o  (inval_addr),
    .inval_gnt_i   (inval_gnt)
  );

  typedef struct {bit sel; int set; logic [31:0] addr;} inval_t;
  typedef struct {bit kind; int cyc;} ack_t;  // kind 0 = full, 1 = selective
  inval_t inval_q[$];
  ack_t   ack_q[$];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  bit gnt_rand = 1'b0;

  // Reference model state
  longint unsigned     m_bank[3][NB_CORES];
  longint unsigned     m_glob[3];
  logic [NB_CORES:0]   m_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_total++;
    n_bad++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  function automatic logic [NB_CORES-1:0] ev_of(input int g);
    case (g)
      0:       return bank_hit;
      1:       return bank_trans;
      default: return bank_miss;
    endcase
  endfunction

  function automatic logic [31:0] bank_act(input int g, input int i);
    case (g)
      0:       return bus_if.bank_hit_count[i];
      1:       return bus_if.bank_trans_count[i];
      default: return bus_if.bank_miss_count[i];
    endcase
  endfunction

  function automatic logic [31:0] glob_act(input int g);
    case (g)
      0:       return bus_if.global_hit_count;
      1:       return bus_if.global_trans_count;
      default: return bus_if.global_miss_count;
    endcase
  endfunction

  function automatic longint unsigned sat32(input longint unsigned v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic model_reset();
    m_en = '0;
    for (int g = 0; g < 3; g++) begin
      m_glob[g] = 0;
      for (int i = 0; i < NB_CORES; i++) m_bank[g][i] = 0;
    end
  endtask

  // One clock of the reference behaviour, from the inputs present at the edge.
  task automatic model_step();
    logic [NB_CORES-1:0] ev;
    int                  n;
    for (int i = 0; i <= NB_CORES; i++)
      if (core_idle[i]) m_en[i] = bus_if.bypass_req;
    if (bus_if.ctrl_clear_regs) begin
      for (int g = 0; g < 3; g++) begin
        m_glob[g] = 0;
        for (int i = 0; i < NB_CORES; i++) m_bank[g][i] = 0;
      end
    end else if (bus_if.ctrl_enable_regs) begin
      for (int g = 0; g < 3; g++) begin
        ev = ev_of(g);
        n  = 0;
        for (int i = 0; i < NB_CORES; i++) begin
          if (ev[i]) begin
            n++;
            m_bank[g][i] = sat32(m_bank[g][i] + 1);
          end
        end
        m_glob[g] = sat32(m_glob[g] + longint'(n));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst_n) model_step();
    #1;
    if (gnt_rand) inval_gnt = 1'($urandom_range(0, 1));
  endtask

  task automatic check_counters(input string tag);
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < NB_CORES; i++)
        check($sformatf("%s_bank%0d_%0d", tag, g, i), 64'(bank_act(g, i)), 64'(m_bank[g][i]));
      check($sformatf("%s_glob%0d", tag, g), 64'(glob_act(g)), 64'(m_glob[g]));
    end
  endtask

  task automatic check_bypass(input string tag);
    check({tag, "_ack"}, 64'(bus_if.bypass_ack), 64'(m_en));
    check({tag, "_en"},  64'(bypass_en),         64'(m_en));
  endtask

  // Pops the scoreboard on every granted invalidation and every rising ack.
  task automatic monitor();
    inval_t      e;
    ack_t        a;
    logic        have_prev = 1'b0;
    logic [38:0] prev      = '0;
    logic        prev_fack = 1'b0;
    logic        prev_sack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_prev = 1'b0;
        prev_fack = 1'b0;
        prev_sack = 1'b0;
      end else begin
        if (inval_req) begin
          check("inval_stall", 64'(fetch_stall), 64'd1);
          if (have_prev) check("inval_hold", 64'({inval_sel, inval_set, inval_addr}), 64'(prev));
          if (inval_gnt) begin
            have_prev = 1'b0;
            if (inval_q.size() == 0) begin
              fail("inval_unexpected", "granted invalidation with nothing expected");
            end else begin
              e = inval_q.pop_front();
              check("inval_sel", 64'(inval_sel), 64'(e.sel));
              if (e.sel) check("inval_addr", 64'(inval_addr), 64'(e.addr));
              else       check("inval_set",  64'(inval_set),  64'(e.set));
            end
          end else begin
            have_prev = 1'b1;
            prev      = {inval_sel, inval_set, inval_addr};
          end
        end else begin
          have_prev = 1'b0;
        end
        if ((bus_if.flush_ack && !prev_fack) || (bus_if.sel_flush_ack && !prev_sack)) begin
          if (ack_q.size() == 0) begin
            fail("ack_unexpected", "ack raised with nothing expected");
          end else begin
            a = ack_q.pop_front();
            check("ack_kind", 64'(bus_if.sel_flush_ack), 64'(a.kind));
            if (a.cyc >= 0) check("ack_cycle", 64'(cyc), 64'(a.cyc));
          end
        end
        prev_fack = bus_if.flush_ack;
        prev_sack = bus_if.sel_flush_ack;
      end
    end
  endtask

  task automatic wait_ack(input bit is_sel, input int budget);
    int k = 0;
    while (!(is_sel ? bus_if.sel_flush_ack : bus_if.flush_ack) && k < budget) begin
      tick();
      k++;
    end
    if (!(is_sel ? bus_if.sel_flush_ack : bus_if.flush_ack))
      fail(is_sel ? "sel_ack_timeout" : "flush_ack_timeout",
           $sformatf("no ack after %0d cycles, ack required", budget));
  endtask

  // kind 0 = full flush, 1 = selective, 2 = both requested in the same cycle.
  task automatic flush_session(input int kind, input logic [31:0] addr, input bit timed);
    int c0 = cyc;
    if (kind != 1) begin
      for (int s = 0; s < NB_SETS; s++) inval_q.push_back('{sel: 1'b0, set: s, addr: '0});
      ack_q.push_back('{kind: 1'b0, cyc: timed ? c0 + NB_SETS + 1 : -1});
    end
    if (kind != 0) begin
      inval_q.push_back('{sel: 1'b1, set: 0, addr: addr});
      // after the full-flush ack: release, back to idle, enter SEL, grant
      ack_q.push_back('{kind: 1'b1,
                        cyc: !timed ? -1 : (kind == 1 ? c0 + 2 : c0 + NB_SETS + 4)});
    end
    bus_if.flush_req      = (kind != 1);
    bus_if.sel_flush_req  = (kind != 0);
    bus_if.sel_flush_addr = addr;
    if (kind != 1) begin
      wait_ack(1'b0, 4000);
      bus_if.flush_req = 1'b0;
    end
    if (kind != 0) begin
      wait_ack(1'b1, 4000);
      bus_if.sel_flush_req = 1'b0;
    end
    tick();
    check("flush_ack_release", 64'(bus_if.flush_ack),     64'd0);
    check("sel_ack_release",   64'(bus_if.sel_flush_ack), 64'd0);
    check("inval_req_idle",    64'(inval_req),            64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [2:0][NB_CORES-1:0][31:0] preset;

    rst_n                   = 1'b0;
    bus_if.bypass_req       = 1'b0;
    bus_if.flush_req        = 1'b0;
    bus_if.sel_flush_req    = 1'b0;
    bus_if.sel_flush_addr   = '0;
    bus_if.ctrl_clear_regs  = 1'b0;
    bus_if.ctrl_enable_regs = 1'b0;
    core_idle  = '0;
    bank_hit   = '0;
    bank_trans = '0;
    bank_miss  = '0;
    inval_gnt  = 1'b0;
    model_reset();
    fork
      monitor();
    join_none

    // Reset state
    tick();
    tick();
    check("rst_flush_ack", 64'(bus_if.flush_ack),     64'd0);
    check("rst_sel_ack",   64'(bus_if.sel_flush_ack), 64'd0);
    check("rst_inval_req", 64'(inval_req),            64'd0);
    check("rst_stall",     64'(fetch_stall),          64'd0);
    check_bypass("rst_bypass");
    check_counters("rst");
    rst_n = 1'b1;

    // Bypass: only idle ports switch
    bus_if.bypass_req = 1'b1;
    core_idle = 5'b10111;
    tick();
    check("byp_partial", 64'(bus_if.bypass_ack), 64'h17);
    check_bypass("byp_partial_m");
    core_idle = 5'b11111;
    tick();
    check("byp_full", 64'(bus_if.bypass_ack), 64'h1F);
    for (int k = 0; k < 30; k++) begin
      bus_if.bypass_req = 1'($urandom_range(0, 1));
      core_idle = 5'($urandom);
      tick();
      check_bypass("byp_rand");
    end

    // Counters: directed accumulation, clear priority, saturation
    bus_if.ctrl_clear_regs = 1'b1;
    tick();
    bus_if.ctrl_clear_regs  = 1'b0;
    bus_if.ctrl_enable_regs = 1'b1;
    bank_hit = 4'b1011;
    repeat (3) tick();
    bank_hit = '0;
    check("hit_b0", 64'(bus_if.bank_hit_count[0]), 64'd3);
    check("hit_b1", 64'(bus_if.bank_hit_count[1]), 64'd3);
    check("hit_b2", 64'(bus_if.bank_hit_count[2]), 64'd0);
    check("hit_b3", 64'(bus_if.bank_hit_count[3]), 64'd3);
    check("hit_glob", 64'(bus_if.global_hit_count), 64'd9);
    check_counters("acc");
    bus_if.ctrl_clear_regs = 1'b1;
    bank_hit = 4'b1111;
    bank_miss = 4'b0110;
    tick();
    check("clr_hit_glob", 64'(bus_if.global_hit_count), 64'd0);
    check_counters("clr");
    bus_if.ctrl_clear_regs  = 1'b0;
    bus_if.ctrl_enable_regs = 1'b0;
    bank_hit  = '0;
    bank_miss = '0;
    tick();
    preset = '0;
    preset[2][0] = 32'hFFFF_FFFE;
    force dut.r_bank = preset;
    #1;
    release dut.r_bank;
    m_bank[2][0] = 64'hFFFF_FFFE;
    bus_if.ctrl_enable_regs = 1'b1;
    bank_miss = 4'b0001;
    tick();
    check("sat_first", 64'(bus_if.bank_miss_count[0]), 64'hFFFF_FFFF);
    tick();
    check("sat_nowrap", 64'(bus_if.bank_miss_count[0]), 64'hFFFF_FFFF);
    check_counters("sat");
    bank_miss = '0;
    bus_if.ctrl_enable_regs = 1'b0;

    // Flushes with grant tied high: exact latencies
    inval_gnt = 1'b1;
    tick();
    flush_session(0, 32'h0, 1'b1);
    flush_session(2, 32'h1C00_8040, 1'b1);
    flush_session(1, 32'hDEAD_BEE0, 1'b1);

    // Flushes with random grant
    gnt_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      flush_session(int'($urandom_range(0, 2)), $urandom, 1'b0);
      repeat (int'($urandom_range(0, 3))) tick();
    end
    gnt_rand  = 1'b0;
    inval_gnt = 1'b0;

    // Counters with random clear / enable / events
    for (int k = 0; k < 150; k++) begin
      bus_if.ctrl_clear_regs  = ($urandom_range(0, 19) == 0);
      bus_if.ctrl_enable_regs = ($urandom_range(0, 3) != 0);
      bank_hit   = 4'($urandom);
      bank_trans = 4'($urandom);
      bank_miss  = 4'($urandom);
      tick();
      check_counters("rand");
    end
    bus_if.ctrl_clear_regs  = 1'b0;
    bus_if.ctrl_enable_regs = 1'b0;
    bank_hit   = '0;
    bank_trans = '0;
    bank_miss  = '0;

    // Async reset in the middle of a sweep
    bus_if.flush_req = 1'b1;
    repeat (3) tick();
    check("sweep_req",   64'(inval_req),   64'd1);
    check("sweep_stall", 64'(fetch_stall), 64'd1);
    check("sweep_set",   64'(inval_set),   64'd0);
    #2;
    rst_n = 1'b0;
    model_reset();
    inval_q.delete();
    ack_q.delete();
    #1;
    check("abort_req",   64'(inval_req),        64'd0);
    check("abort_stall", 64'(fetch_stall),      64'd0);
    check("abort_ack",   64'(bus_if.flush_ack), 64'd0);
    bus_if.flush_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_abort_req", 64'(inval_req), 64'd0);
    check_bypass("post_abort");
    check_counters("post_abort");

    check("inval_q_left", 64'(inval_q.size()), 64'd0);
    check("ack_q_left",   64'(ack_q.size()),   64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
